// File: rtl/key_encoder_pkg.sv
// Shared types and constants for the key encoder: FSM states, code width,
// the enable value that activates the block, and the priority encoder.
package key_encoder_pkg;

  localparam int CODE_W = 3;
  localparam int KEY_W = 8;
  localparam int CNT_W = 8;
  localparam logic [2:0] ENABLE_ACTIVE = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // hit=0 means "no key pressed"; idx is only meaningful when hit=1
  typedef struct packed {
    logic              hit;
    logic [CODE_W-1:0] idx;
  } cand_t;

  // Highest-index active-low line wins; later loop iterations override earlier ones
  function automatic cand_t prio_encode(input logic [KEY_W-1:0] lines_n);
    cand_t res;
    res = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (!lines_n[i]) begin
        res.hit = 1'b1;
        res.idx = CODE_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small code queue with combinational head read, so a push into an empty
// queue is visible at the output right after the writing edge.
module key_fifo
  import key_encoder_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer bit distinguishes a full queue from an empty one
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A simultaneous pop frees the slot, so push into a full queue then succeeds
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Head is forced to zero while empty so stale storage never leaks out
  assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // Storage array, no reset needed since reads are masked while empty
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Read/write pointers wrap naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

endmodule

// File: rtl/key_encoder.sv
// Debounced 8-key priority encoder: synchronizes the key lines, qualifies a
// stable press with a small FSM and queues one code per accepted press.
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        enable,
  input  logic [KEY_W-1:0]  key_n,
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              any,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0]  sync1_reg;
  logic [KEY_W-1:0]  sync2_reg;
  cand_t             cand;
  logic              same;
  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CODE_W-1:0] latched_reg;
  logic              push_reg;
  logic              any_reg;
  logic              overflow_reg;
  logic              pop;
  logic              full;
  logic              empty;

  // Two-flop synchronizer; idles at all-ones (no key pressed)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
    end
  end

  // Candidate is suppressed entirely while the block is not enabled
  always_comb begin
    cand = '0;
    if (enable == ENABLE_ACTIVE) begin
      cand = prio_encode(sync2_reg);
    end
  end

  assign same = cand.hit && (cand.idx == latched_reg);

  // Debounce FSM; push is registered so it lands in the FIFO one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      latched_reg <= '0;
      push_reg    <= 1'b0;
      any_reg     <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cand.hit) begin
            state_reg   <= QUALIFY;
            latched_reg <= cand.idx;
            cnt_reg     <= CNT_W'(1);
          end
        end
        QUALIFY: begin
          if (same) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg >= DEB_LAST) begin
              state_reg <= HELD;
              push_reg  <= 1'b1;
              any_reg   <= 1'b1;
            end
          end else if (!cand.hit) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            latched_reg <= cand.idx;
            cnt_reg     <= CNT_W'(1);
          end
        end
        HELD: begin
          if (!same) begin
            state_reg <= RELEASE;
            cnt_reg   <= CNT_W'(1);
            any_reg   <= 1'b0;
          end
        end
        RELEASE: begin
          if (same) begin
            // Bounce back to the same key: no new push
            state_reg <= HELD;
            cnt_reg   <= '0;
            any_reg   <= 1'b1;
          end else if (cnt_reg >= DEB_LAST) begin
            if (cand.hit) begin
              state_reg   <= QUALIFY;
              latched_reg <= cand.idx;
              cnt_reg     <= CNT_W'(1);
            end else begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign pop   = valid && ready;
  assign valid = !empty;
  assign any   = any_reg;

  // Sticky overflow: a push dropped because the queue was full with no pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (push_reg && full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;

  key_fifo #(
    .WIDTH(CODE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_reg),
    .pop  (pop),
    .din  (latched_reg),
    .dout (code),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder: expected codes are queued as presses are
// driven and compared whenever the DUT hands a code over.
module tb_key_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] enable;
  logic [7:0] key_n;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic       any;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int p0;
  int exp_q[$];
  int press_codes[5] = '{1, 2, 3, 4, 6};

  key_encoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .key_n   (key_n),
    .ready   (ready),
    .code    (code),
    .valid   (valid),
    .any     (any),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake pops one expected code
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_code", int'(code), -1);
      end else begin
        check("code", int'(code), exp_q.pop_front());
      end
      $display("pop code=%0d t=%0t", code, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 3'd4;
    key_n  = 8'hff;
    ready  = 1'b1;
    tick(2);
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_any", int'(any), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    tick(2);

    // Single press of key 3 with exact latency
    exp_q.push_back(3);
    p0 = pops;
    key_n = 8'hf7;
    tick(1);                       // edge t0
    tick(5);                       // t0+5
    check("lat_valid_early", int'(valid), 0);
    check("lat_any_held", int'(any), 1);
    tick(1);                       // t0+6
    check("lat_valid", int'(valid), 1);
    check("lat_code", int'(code), 3);
    tick(3);
    check("single_push", pops - p0, 1);
    key_n = 8'hff;
    tick(10);
    check("any_released", int'(any), 0);

    // Bouncing key 5, then stable
    exp_q.push_back(5);
    p0 = pops;
    repeat (3) begin
      key_n = 8'hdf; tick(2);
      key_n = 8'hff; tick(2);
    end
    check("bounce_nopush", pops - p0, 0);
    check("bounce_valid", int'(valid), 0);
    key_n = 8'hdf;
    tick(10);
    check("bounce_final", pops - p0, 1);
    key_n = 8'hff;
    tick(10);

    // Priority: keys 5 and 7 together
    exp_q.push_back(7);
    p0 = pops;
    key_n = 8'h5f;
    tick(10);
    check("prio_push", pops - p0, 1);
    key_n = 8'hff;
    tick(10);

    // Overflow with consumer stalled
    ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(press_codes[i]);
      key_n = 8'hff ^ (8'h01 << press_codes[i]);
      tick(8);
      key_n = 8'hff;
      tick(8);
    end
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid", int'(valid), 1);
    check("ovf_head", int'(code), 1);
    tick(3);
    check("ovf_head_stable", int'(code), 1);
    ready = 1'b1;
    tick(8);
    check("ovf_drained", pops - p0, 4);
    check("ovf_empty", int'(valid), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Disabled block ignores keys; enabling picks up the held key
    enable = 3'd5;
    p0 = pops;
    key_n = 8'hfb;
    tick(10);
    check("dis_any", int'(any), 0);
    check("dis_valid", int'(valid), 0);
    check("dis_nopush", pops - p0, 0);
    exp_q.push_back(2);
    enable = 3'd4;
    tick(10);
    check("en_push", pops - p0, 1);
    key_n = 8'hff;
    tick(10);

    // Reset during qualification of key 6
    key_n = 8'hbf;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("midrst_any", int'(any), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_code", int'(code), 0);
    check("midrst_overflow", int'(overflow), 0);
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(6);
    p0 = pops;
    tick(1);                       // r0
    tick(5);                       // r0+5
    check("requal_early", int'(valid), 0);
    tick(1);                       // r0+6
    check("requal_valid", int'(valid), 1);
    check("requal_code", int'(code), 6);
    tick(3);
    check("requal_push", pops - p0, 1);
    key_n = 8'hff;
    tick(10);

    check("queue_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
